// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, feeder state encoding and index-width helpers
//
// Purpose: common definitions for the Stage2 feeder slice.
//   DEF_DATA_WIDTH : default signed Q4.4 data/weight width
//   data_t         : signed data word at the default width
//   feeder_state_e : feeder sequencer states
//   idx_w()        : bits needed to index n entries (never less than 1)
package nn_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_regfile.sv
// rtl/weight_regfile.sv - S1_NUM x S2_NUM weight store with range-checked write and row read
//
// Ports:
//   clk, reset : clock, asynchronous active-low reset (clears every weight)
//   we         : write strobe (already qualified by the caller's state)
//   wr_row/col : write address; out-of-range addresses are dropped
//   wr_data    : weight to store
//   err        : this cycle's write was dropped for being out of range
//   rd_row     : beat index selecting the row to present
//   rd_data    : all S2_NUM weights of the selected row
module weight_regfile
  import nn_pkg::*;
#(
  parameter int S1_NUM     = 8,
  parameter int S2_NUM     = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 we,
  input  logic [idx_w(S1_NUM)-1:0]             wr_row,
  input  logic [idx_w(S2_NUM)-1:0]             wr_col,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 err,
  input  logic [idx_w(S1_NUM)-1:0]             rd_row,
  output logic [S2_NUM-1:0][DATA_WIDTH-1:0]    rd_data
);

  logic [S1_NUM-1:0][S2_NUM-1:0][DATA_WIDTH-1:0] w_q, w_d;
  logic in_range;

  // Index ports may be wider than the array when S1_NUM/S2_NUM are not powers of two.
  assign in_range = (int'(wr_row) < S1_NUM) && (int'(wr_col) < S2_NUM);

  always_comb begin
    w_d = w_q;
    if (we && in_range) begin
      w_d[wr_row][wr_col] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign err     = we && !in_range;
  assign rd_data = w_q[rd_row];

endmodule

// File: rtl/stage2_feeder.sv
// rtl/stage2_feeder.sv - sequences one activation vector plus weight columns into Stage2
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_vector/valid/ready : Stage1 activation vector handshake (ready only in IDLE)
//   wr_en/row/col/data  : weight write port, honoured only in IDLE
//   wr_err              : sticky, set when any write is dropped
//   s2_inp/weights/enable : one beat per cycle to Stage2, S1_NUM contiguous beats
//   result_valid        : one-cycle pulse when Stage2 out_vector is valid
//   busy                : feeder not IDLE
module stage2_feeder
  import nn_pkg::*;
#(
  parameter int S1_NUM       = 8,
  parameter int S2_NUM       = 8,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [S1_NUM-1:0][DATA_WIDTH-1:0] in_vector,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              wr_en,
  input  logic [idx_w(S1_NUM)-1:0]          wr_row,
  input  logic [idx_w(S2_NUM)-1:0]          wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_err,
  output logic [DATA_WIDTH-1:0]             s2_inp,
  output logic [S2_NUM-1:0][DATA_WIDTH-1:0] s2_weights,
  output logic                              s2_enable,
  output logic                              result_valid,
  output logic                              busy
);

  localparam int RW  = idx_w(S1_NUM);
  localparam int DCW = idx_w(DRAIN_CYCLES);

  feeder_state_e                       state_q, state_d;
  logic [RW-1:0]                       beat_q, beat_d;
  logic [DCW-1:0]                      drain_q, drain_d;
  logic [S1_NUM-1:0][DATA_WIDTH-1:0]   vec_q, vec_d;
  logic                                wr_err_q, wr_err_d;

  logic                                rf_we;
  logic                                rf_err;
  logic [S2_NUM-1:0][DATA_WIDTH-1:0]   rf_row;

  // Writes outside IDLE never reach the array; an accept in the same cycle still
  // lets beat 0 see the new weight because the row is read from the registered array.
  assign rf_we = wr_en && (state_q == IDLE);

  weight_regfile #(
    .S1_NUM     (S1_NUM),
    .S2_NUM     (S2_NUM),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .err     (rf_err),
    .rd_row  (beat_q),
    .rd_data (rf_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      drain_q  <= '0;
      vec_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      drain_q  <= drain_d;
      vec_q    <= vec_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    vec_d    = vec_q;
    wr_err_d = wr_err_q | rf_err | (wr_en && (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d   = in_vector;
          beat_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (int'(beat_q) == S1_NUM - 1) begin
          beat_d  = '0;
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else begin
          beat_d = beat_q + RW'(1);
        end
      end
      DRAIN: begin
        if (int'(drain_q) == DRAIN_CYCLES - 1) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage2 outputs depend on registered state only, never on an input.
  always_comb begin
    in_ready     = (state_q == IDLE);
    busy         = (state_q != IDLE);
    result_valid = (state_q == DONE);
    wr_err       = wr_err_q;
    s2_enable    = 1'b0;
    s2_inp       = '0;
    s2_weights   = '0;
    if (state_q == STREAM) begin
      s2_enable  = 1'b1;
      s2_inp     = vec_q[beat_q];
      s2_weights = rf_row;
    end
  end

endmodule

// File: tb/tb_stage2_feeder.sv
// tb/tb_stage2_feeder.sv - directed self-checking bench for stage2_feeder
module tb_stage2_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [7:0][7:0] in_vector;
  logic            in_valid, in_ready, wr_en, wr_err, s2_enable, result_valid, busy;
  logic [2:0]      wr_row, wr_col;
  logic [7:0]      wr_data, s2_inp;
  logic [7:0][7:0] s2_weights;

  logic [7:0][7:0] in_vector0;
  logic            in_valid0, in_ready0, wr_en0, wr_err0, s2_enable0, result_valid0, busy0;
  logic [2:0]      wr_row0, wr_col0;
  logic [7:0]      wr_data0, s2_inp0;
  logic [5:0][7:0] s2_weights0;

  stage2_feeder #(.S1_NUM(8), .S2_NUM(8), .DATA_WIDTH(8), .DRAIN_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_vector(in_vector), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_err(wr_err),
    .s2_inp(s2_inp), .s2_weights(s2_weights), .s2_enable(s2_enable),
    .result_valid(result_valid), .busy(busy)
  );

  stage2_feeder #(.S1_NUM(8), .S2_NUM(6), .DATA_WIDTH(8), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_vector(in_vector0), .in_valid(in_valid0), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_row(wr_row0), .wr_col(wr_col0), .wr_data(wr_data0), .wr_err(wr_err0),
    .s2_inp(s2_inp0), .s2_weights(s2_weights0), .s2_enable(s2_enable0),
    .result_valid(result_valid0), .busy(busy0)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] model_w [8][8];
  logic [7:0][7:0] exp_wt;

  task automatic wr_main(input int r, input int c, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_data = d;
    model_w[r][c] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_chk++; if (s2_enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", s2_enable); else n_pass++;
    n_chk++; if (s2_inp !== 8'h00) $display("FAIL reset_inp: got %h expected 00", s2_inp); else n_pass++;
    n_chk++; if (s2_weights !== 64'h0) $display("FAIL reset_weights: got %h expected 0", s2_weights); else n_pass++;
    n_chk++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b expected 0", result_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_chk++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b expected 0", wr_err); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_stream;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 8; j++)
        wr_main(b, j, 8'h10);
    @(negedge clk);
    for (int b = 0; b < 8; b++) in_vector[b] = 8'(16 * (b + 1));
    in_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        in_vector = {8{8'h55}};
      end
      for (int j = 0; j < 8; j++) exp_wt[j] = (c >= 1 && c <= 8) ? model_w[c-1][j] : 8'h00;
      n_chk++; if (s2_enable !== (c >= 1 && c <= 8)) $display("FAIL stream_enable c=%0d: got %b", c, s2_enable); else n_pass++;
      n_chk++; if (s2_inp !== ((c <= 8) ? 8'(16 * c) : 8'h00)) $display("FAIL stream_inp c=%0d: got %h expected %h", c, s2_inp, (c <= 8) ? 8'(16 * c) : 8'h00); else n_pass++;
      n_chk++; if (s2_weights !== exp_wt) $display("FAIL stream_weights c=%0d: got %h expected %h", c, s2_weights, exp_wt); else n_pass++;
      n_chk++; if (result_valid !== (c == 10)) $display("FAIL stream_result_valid c=%0d: got %b expected %b", c, result_valid, c == 10); else n_pass++;
      n_chk++; if (in_ready !== (c >= 11)) $display("FAIL stream_in_ready c=%0d: got %b expected %b", c, in_ready, c >= 11); else n_pass++;
      n_chk++; if (busy !== (c <= 10)) $display("FAIL stream_busy c=%0d: got %b expected %b", c, busy, c <= 10); else n_pass++;
    end
  endtask

  task automatic test_same_cycle_write;
    @(negedge clk);
    wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd5; wr_data = 8'hF0;
    model_w[3][5] = 8'hF0;
    for (int b = 0; b < 8; b++) in_vector[b] = 8'(b + 1);
    in_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin wr_en = 1'b0; in_valid = 1'b0; end
      if (c <= 8) begin
        for (int j = 0; j < 8; j++) exp_wt[j] = model_w[c-1][j];
        n_chk++; if (s2_weights !== exp_wt) $display("FAIL samecyc_weights beat=%0d: got %h expected %h", c - 1, s2_weights, exp_wt); else n_pass++;
        n_chk++; if (s2_inp !== 8'(c)) $display("FAIL samecyc_inp beat=%0d: got %h expected %h", c - 1, s2_inp, 8'(c)); else n_pass++;
      end
      if (c == 4) begin
        n_chk++; if (s2_weights[5] !== 8'hF0) $display("FAIL samecyc_w35: got %h expected f0", s2_weights[5]); else n_pass++;
      end
    end
  endtask

  task automatic test_write_err;
    n_chk++; if (wr_err !== 1'b0) $display("FAIL err_initial: got %b expected 0", wr_err); else n_pass++;
    @(negedge clk);
    in_vector = {8{8'h11}};
    in_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c == 5) begin wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'h7F; end
      if (c == 6) begin
        wr_en = 1'b0;
        n_chk++; if (wr_err !== 1'b1) $display("FAIL err_set_stream: got %b expected 1", wr_err); else n_pass++;
      end
    end
    n_chk++; if (wr_err !== 1'b1) $display("FAIL err_sticky_pass: got %b expected 1", wr_err); else n_pass++;
    wr_main(1, 1, 8'h22);
    n_chk++; if (wr_err !== 1'b1) $display("FAIL err_sticky_write: got %b expected 1", wr_err); else n_pass++;
    @(negedge clk);
    in_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c <= 8) begin
        for (int j = 0; j < 8; j++) exp_wt[j] = model_w[c-1][j];
        n_chk++; if (s2_weights !== exp_wt) $display("FAIL err_w_unchanged beat=%0d: got %h expected %h", c - 1, s2_weights, exp_wt); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc_t[$];
    int run_len, runs, n_acc;
    logic overlap, stop, pend;
    logic [7:0][7:0] exp_vec;
    run_len = 0; runs = 0; n_acc = 0; overlap = 1'b0; stop = 1'b0; pend = 1'b0; exp_vec = '0;
    @(negedge clk);
    for (int b = 0; b < 8; b++) in_vector[b] = 8'(b + 1);
    in_valid = 1'b1;
    for (int t = 0; t < 45; t++) begin
      if (s2_enable) begin
        n_chk++; if (s2_inp !== exp_vec[run_len[2:0]] || run_len > 7) $display("FAIL b2b_inp t=%0d: got %h expected %h", t, s2_inp, exp_vec[run_len[2:0]]); else n_pass++;
        run_len++;
      end else if (run_len != 0) begin
        n_chk++; if (run_len != 8) $display("FAIL b2b_run_len: got %0d expected 8", run_len); else n_pass++;
        runs++;
        run_len = 0;
      end
      if (s2_enable && in_ready) overlap = 1'b1;
      if (stop) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        acc_t.push_back(t);
        exp_vec = in_vector;
        n_acc++;
        if (n_acc == 3) stop = 1'b1;
        pend = 1'b1;
      end else if (pend) begin
        for (int b = 0; b < 8; b++) in_vector[b] = 8'(n_acc * 32 + b + 1);
        pend = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++; if (n_acc != 3) $display("FAIL b2b_accepts: got %0d expected 3", n_acc); else n_pass++;
    n_chk++; if (runs != 3) $display("FAIL b2b_runs: got %0d expected 3", runs); else n_pass++;
    n_chk++; if (overlap !== 1'b0) $display("FAIL b2b_overlap: got %b expected 0", overlap); else n_pass++;
    n_chk++;
    if (acc_t.size() < 3) $display("FAIL b2b_spacing: got %0d accepts expected 3", acc_t.size());
    else if (acc_t[1] - acc_t[0] != 11 || acc_t[2] - acc_t[1] != 11)
      $display("FAIL b2b_spacing: got %0d,%0d expected 11,11", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    for (int b = 0; b < 8; b++) in_vector[b] = 8'(b + 1);
    in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
    end
    n_chk++; if (s2_enable !== 1'b1 || s2_inp !== 8'h06) $display("FAIL arst_pre_beat5: got en=%b inp=%h expected en=1 inp=06", s2_enable, s2_inp); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (s2_enable !== 1'b0) $display("FAIL arst_enable: got %b expected 0", s2_enable); else n_pass++;
    n_chk++; if (s2_inp !== 8'h00) $display("FAIL arst_inp: got %h expected 00", s2_inp); else n_pass++;
    n_chk++; if (s2_weights !== 64'h0) $display("FAIL arst_weights: got %h expected 0", s2_weights); else n_pass++;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL arst_busy_ready: got busy=%b ready=%b expected 0/1", busy, in_ready); else n_pass++;
    n_chk++; if (wr_err !== 1'b0) $display("FAIL arst_wr_err: got %b expected 0", wr_err); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (result_valid !== 1'b0) $display("FAIL arst_no_result: got %b expected 0", result_valid); else n_pass++;
    end
    reset = 1'b1;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 8; j++)
        model_w[b][j] = 8'h00;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL arst_release_ready: got %b expected 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c <= 8) begin
        n_chk++; if (s2_weights !== 64'h0) $display("FAIL arst_w_zero beat=%0d: got %h expected 0", c - 1, s2_weights); else n_pass++;
      end
      n_chk++; if (result_valid !== (c == 10)) $display("FAIL arst_pass_result c=%0d: got %b expected %b", c, result_valid, c == 10); else n_pass++;
    end
  endtask

  task automatic test_drain0;
    logic [5:0][7:0] e0;
    n_chk++; if (wr_err0 !== 1'b0) $display("FAIL d0_err_initial: got %b expected 0", wr_err0); else n_pass++;
    @(negedge clk);
    wr_en0 = 1'b1; wr_row0 = 3'd2; wr_col0 = 3'd5; wr_data0 = 8'h44;
    @(negedge clk);
    n_chk++; if (wr_err0 !== 1'b0) $display("FAIL d0_err_valid_write: got %b expected 0", wr_err0); else n_pass++;
    wr_col0 = 3'd7; wr_data0 = 8'h33;
    @(negedge clk);
    wr_en0 = 1'b0;
    n_chk++; if (wr_err0 !== 1'b1) $display("FAIL d0_err_range: got %b expected 1", wr_err0); else n_pass++;
    for (int b = 0; b < 8; b++) in_vector0[b] = 8'(8'hA0 + b);
    in_valid0 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) in_valid0 = 1'b0;
      e0 = '0;
      if (c == 3) e0[5] = 8'h44;
      if (c <= 8) begin
        n_chk++; if (s2_inp0 !== 8'(8'hA0 + c - 1)) $display("FAIL d0_inp c=%0d: got %h expected %h", c, s2_inp0, 8'(8'hA0 + c - 1)); else n_pass++;
        n_chk++; if (s2_weights0 !== e0) $display("FAIL d0_weights c=%0d: got %h expected %h", c, s2_weights0, e0); else n_pass++;
      end
      n_chk++; if (result_valid0 !== (c == 9)) $display("FAIL d0_result c=%0d: got %b expected %b", c, result_valid0, c == 9); else n_pass++;
      n_chk++; if (in_ready0 !== (c >= 10)) $display("FAIL d0_in_ready c=%0d: got %b expected %b", c, in_ready0, c >= 10); else n_pass++;
    end
  endtask

  initial begin
    in_vector = '0; in_valid = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    in_vector0 = '0; in_valid0 = 1'b0; wr_en0 = 1'b0; wr_row0 = '0; wr_col0 = '0; wr_data0 = '0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 8; j++)
        model_w[b][j] = 8'h00;
    test_reset();
    test_stream();
    test_same_cycle_write();
    test_write_err();
    test_back_to_back();
    test_async_reset();
    test_drain0();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
